axi_wr_slave_mem: RTL and testbench
===================================

// Module: axi_wr_slave_mem
// PURPOSE
//  AXI4 write-channel responder (slave): accepts AW/W bursts from an AXI master and
//  returns the B response. Each beat is written into a simple word-addressed SRAM port.
//  Acts as the memory-side endpoint for write-DMA masters in block-level benches and
//  in the on-chip scratchpad. One transaction outstanding; no read channel.
// PARAMETERS
//  AXI_DATA_WIDTH  32            data bus width, bits
//  AXI_ADDR_WIDTH  32            byte address width
//  AXI_STRB_WIDTH  DATA/8        wstrb width; bytes per beat
//  AXI_ID_WIDTH    8             awid/bid width
//  MEM_ADDR_WIDTH  10            SRAM word-address width (window = 2^MEM_ADDR_WIDTH words)
//  BASE_ADDR       0             byte address mapped to SRAM word 0
// PORTS
//  clk            in   1               clock, all logic on rising edge
//  rst            in   1               synchronous reset, active-high
//  s_axi_awid     in   AXI_ID_WIDTH    write ID
//  s_axi_awaddr   in   AXI_ADDR_WIDTH  burst start byte address
//  s_axi_awlen    in   8               beats-1
//  s_axi_awsize   in   3               ignored; beat size is always AXI_STRB_WIDTH bytes
//  s_axi_awburst  in   2               00 FIXED, 01 INCR, 10 WRAP (handled as INCR)
//  s_axi_awvalid  in   1               AW valid
//  s_axi_awready  out  1               AW ready
//  s_axi_wdata    in   AXI_DATA_WIDTH  write data
//  s_axi_wstrb    in   AXI_STRB_WIDTH  byte enables
//  s_axi_wlast    in   1               last beat flag from master
//  s_axi_wvalid   in   1               W valid
//  s_axi_wready   out  1               W ready
//  s_axi_bid      out  AXI_ID_WIDTH    response ID (= captured awid)
//  s_axi_bresp    out  2               00 OKAY, 10 SLVERR
//  s_axi_bvalid   out  1               B valid
//  s_axi_bready   in   1               B ready
//  mem_we         out  1               SRAM write enable (one cycle per accepted beat)
//  mem_addr       out  MEM_ADDR_WIDTH  SRAM word address
//  mem_wdata      out  AXI_DATA_WIDTH  SRAM write data
//  mem_wstrb      out  AXI_STRB_WIDTH  SRAM byte enables
// BEHAVIOUR
//  - Reset: state IDLE; awready, wready, bvalid, mem_we = 0; bid, bresp, beat count = 0.
//    awready, wready, bvalid are registered; awready rises the first cycle after rst falls.
//  - FSM IDLE -> DATA on AW handshake (cycle N): latch id, addr, len, burst; clear beat
//    counter and error flag; awready=0; wready=1 from N+1.
//  - DATA: each W handshake drives mem_we=1 combinationally that cycle with
//    mem_addr = ((addr-BASE_ADDR) >> log2(AXI_STRB_WIDTH)) truncated to MEM_ADDR_WIDTH,
//    mem_wdata=wdata, mem_wstrb=wstrb. Zero-latency write. Low address bits are dropped.
//    INCR/WRAP: addr += AXI_STRB_WIDTH per beat; FIXED: addr held.
//  - Burst ends on beat count == awlen+1 regardless of wlast (cycle M): DATA -> RESP,
//    wready=0, bvalid=1 at M+1. wlast on a non-final beat, or missing on final beat,
//    sets sticky error -> bresp=SLVERR; all awlen+1 beats are still written.
//  - RESP: bvalid, bid, bresp held stable until bready; B handshake at K -> IDLE,
//    awready=1 at K+1. AW is never accepted while DATA/RESP (single outstanding).
//  - W beats presented before the AW handshake wait (wready=0); not buffered.
//  - awlen=255 supported (8-bit beat counter, 9-bit compare). Address wraps at
//    2^AXI_ADDR_WIDTH without error.
//  - rst mid-burst/mid-response: abandon transaction, no B issued, all outputs reset
//    values next cycle.
// CONFIGURATION
//  AXI_WR_SLAVE_BOUNDS_CHECK_EN defined: per-beat check; beat is out of range if
//    addr < BASE_ADDR or (addr-BASE_ADDR)>>log2(STRB) >= 2^MEM_ADDR_WIDTH.
//    Out-of-range beats are accepted (wready) but mem_we=0, and sticky error -> SLVERR.
//  Not defined: no check; mem_addr truncation aliases into the window; bresp OKAY
//    unless wlast mismatch.
// TESTING
//  1 AW addr=0x10 len=3 INCR id=5; 4 beats D0..D3, wlast on 4th -> mem_we at words
//    4,5,6,7 with D0..D3; bid=5 bresp=00; awready=1 the cycle after B handshake.
//  2 Same as 1 with bready low 5 cycles -> bvalid/bid/bresp stable; second AW held
//    (awready=0) until B handshake.
//  3 len=3 INCR with wlast on beat 2 -> 4 writes still issued, bresp=10.
//  4 FIXED addr=0x8 len=2 strb=4'b0011 -> 3 writes all to word 2, mem_wstrb=0011, OKAY.
//  5 MEM_ADDR_WIDTH=10, addr=0x1000 len=0: with _EN -> mem_we stays 0, bresp=10;
//    without -> write to word 0, bresp=00.
//  6 rst pulsed after beat 1 of len=7 burst -> no bvalid; awready=0 during rst, 1 after;
//    next AW len=0 completes with bresp=00.

Source files
------------

// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel responder that writes each accepted beat into a word-addressed SRAM port.
// One transaction outstanding; no read channel.
// Optional feature: define AXI_WR_SLAVE_BOUNDS_CHECK_EN to suppress writes outside the SRAM window
// and report SLVERR for them. Without it, addresses alias into the window by truncation.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A master keeps valid and payload stable until that edge. This slave drives awready,
// wready and bvalid from flops. bid and bresp stay stable while bvalid is high.
module axi_wr_slave_mem #(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int                        AXI_ID_WIDTH   = 8,
  parameter int                        MEM_ADDR_WIDTH = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
  output logic [AXI_STRB_WIDTH-1:0] mem_wstrb,
  output logic [1:0]                dbg_state
);

  localparam int LSB = $clog2(AXI_STRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                burst_q, burst_d;
  logic                      err_q, err_d;

  logic                      aw_hs, w_hs, b_hs;
  logic                      last_beat, beat_ok, err_nxt, below_base;
  logic [AXI_ADDR_WIDTH:0]   off_ext;
  logic [AXI_ADDR_WIDTH-1:0] word;

  // Offset from the window base. The extra top bit is the borrow, meaning addr is below the base.
  assign off_ext    = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign below_base = off_ext[AXI_ADDR_WIDTH];
  assign word       = off_ext[AXI_ADDR_WIDTH-1:0] >> LSB;

`ifdef AXI_WR_SLAVE_BOUNDS_CHECK_EN
  assign beat_ok = !below_base && ((word >> MEM_ADDR_WIDTH) == '0);
  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, word};
`else
  assign beat_ok = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, word, below_base};
`endif

  assign aw_hs     = (state_q == IDLE) && s_axi_awvalid && awready_q;
  assign w_hs      = (state_q == DATA) && s_axi_wvalid && wready_q;
  assign b_hs      = (state_q == RESP) && bvalid_q && s_axi_bready;
  // The burst ends when the number of beats seen reaches awlen+1.
  assign last_beat = ({1'b0, cnt_q} + 9'd1) == ({1'b0, len_q} + 9'd1);
  // A beat is an error if wlast disagrees with the beat count, or if the beat falls outside the window.
  assign err_nxt   = err_q || (s_axi_wlast != last_beat) || !beat_ok;

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign mem_we        = w_hs && beat_ok;
  assign mem_addr      = word[MEM_ADDR_WIDTH-1:0];
  assign mem_wdata     = s_axi_wdata;
  assign mem_wstrb     = s_axi_wstrb;
  assign dbg_state     = state_q;

  // Next-state logic: burst sequencing, address stepping and response generation.
  always_comb begin
    state_d  = state_q;
    wready_d = wready_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d  = DATA;
          bid_d    = s_axi_awid;
          addr_d   = s_axi_awaddr;
          len_d    = s_axi_awlen;
          burst_d  = s_axi_awburst;
          cnt_d    = 8'd0;
          err_d    = 1'b0;
          wready_d = 1'b1;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d  = err_nxt;
          cnt_d  = cnt_q + 8'd1;
          // A FIXED burst writes every beat to the same address. WRAP bursts step like INCR.
          addr_d = (burst_q == 2'b00) ? addr_q
                                      : addr_q + AXI_ADDR_WIDTH'(AXI_STRB_WIDTH);
          if (last_beat) begin
            state_d  = RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = err_nxt ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // awready is raised only in IDLE, so a new AW is never accepted during DATA or RESP.
    awready_d = (state_d == IDLE);
  end

  // State and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      addr_q    <= '0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      burst_q   <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: directed scenarios plus randomized bursts checked against a transaction-level model.
module tb_axi_wr_slave_mem;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          SW   = DW / 8;
  localparam int          IW   = 8;
  localparam int          MW   = 10;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          EW   = MW + DW + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          mem_we;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [1:0]    dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  axi_wr_slave_mem #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_STRB_WIDTH(SW),
    .AXI_ID_WIDTH(IW), .MEM_ADDR_WIDTH(MW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: the transaction in flight
  logic [31:0]   t_addr;
  logic [1:0]    t_burst;
  logic [7:0]    t_len;
  logic [IW-1:0] t_id;
  bit            t_err;

  function automatic logic [31:0] beat_addr(input int i);
    return (t_burst == 2'b00) ? t_addr : t_addr + 32'(i * SW);
  endfunction

  function automatic bit in_window(input logic [31:0] a);
`ifdef AXI_WR_SLAVE_BOUNDS_CHECK_EN
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && ((d / SW) < (longint'(1) << MW));
`else
    return (a === a);
`endif
  endfunction

  function automatic logic [MW-1:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) / SW;
    return w[MW-1:0];
  endfunction

  // scoreboard: each SRAM write must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_write_unexpected got addr=%0d data=%h strb=%b, expected no write",
                 mem_addr, mem_wdata, mem_wstrb);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin
          n_err++;
          $display("FAIL mem_write got addr=%0d data=%h strb=%b, expected addr=%0d data=%h strb=%b",
                   mem_addr, mem_wdata, mem_wstrb, e[EW-1 -: MW], e[SW +: DW], e[SW-1:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic set_model(input logic [IW-1:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [1:0] burst);
    t_id = id; t_addr = a; t_len = len; t_burst = burst; t_err = 1'b0;
  endtask

  task automatic do_aw(input logic [IW-1:0] id, input logic [31:0] a,
                       input logic [7:0] len, input logic [1:0] burst);
    bit ok;
    set_model(id, a, len, burst);
    awid = id; awaddr = a; awlen = len; awburst = burst;
    awsize = 3'($urandom_range(0, 7)); awvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = (awready === 1'b1);
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL aw_handshake got awready=%b, required 1 within 100 cycles", awready);
    end
  endtask

  task automatic drive_beat(input int i, input bit last, input logic [SW-1:0] strb_fix);
    bit ok;
    logic [31:0] a;
    wdata = $urandom;
    wstrb = (strb_fix != '0) ? strb_fix : SW'($urandom);
    wlast = last; wvalid = 1'b1;
    a = beat_addr(i);
    if (in_window(a)) exp_q.push_back({word_of(a), wdata, wstrb});
    else t_err = 1'b1;
    if (last != (i == int'(t_len))) t_err = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = (wready === 1'b1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL w_handshake beat=%0d got wready=%b, required 1 within 100 cycles", i, wready);
    end
  endtask

  // last_at = beat index carrying wlast (beyond t_len means wlast never asserted)
  task automatic do_w(input int last_at, input logic [SW-1:0] strb_fix, input int gap_pct);
    for (int i = 0; i <= int'(t_len); i++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        @(posedge clk); #1;
      end
      drive_beat(i, i == last_at, strb_fix);
    end
  endtask

  task automatic do_b(input int delay);
    bit ok;
    logic [1:0] eresp;
    eresp = t_err ? 2'b10 : 2'b00;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = (bvalid === 1'b1);
      if (!ok) begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL bvalid_timeout got bvalid=%b, required 1 within 100 cycles", bvalid);
      return;
    end
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if ({bvalid, bid, bresp, awready} !== {1'b1, t_id, eresp, 1'b0}) begin
        n_err++;
        $display("FAIL b_stall got bvalid=%b bid=%h bresp=%b awready=%b, required 1 %h %b 0",
                 bvalid, bid, bresp, awready, t_id, eresp);
      end
    end
    @(posedge clk); #1; bready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bvalid, bid, bresp} !== {1'b1, t_id, eresp}) begin
      n_err++;
      $display("FAIL b_resp got bvalid=%b bid=%h bresp=%b, required 1 %h %b",
               bvalid, bid, bresp, t_id, eresp);
    end
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({awready, bvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL after_b got awready=%b bvalid=%b, required 1 0", awready, bvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_writes got %0d missing writes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; awvalid = 0; wvalid = 0; bready = 0; wlast = 0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, mem_we, bid, bresp} !== {4'b0000, {IW{1'b0}}, 2'b00}) begin
      n_err++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b we=%b bid=%h bresp=%b, required all 0",
               awready, wready, bvalid, mem_we, bid, bresp);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (awready !== 1'b0) begin
      n_err++; $display("FAIL awready_before_edge got %b, required 0", awready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (awready !== 1'b1) begin
      n_err++; $display("FAIL awready_after_reset got %b, required 1", awready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_aw(8'd5, 32'h10, 8'd3, 2'b01);
    do_w(3, '0, 0);
    do_b(0);
    check_drained("basic");
  endtask

  task automatic test_bready_stall();
    do_aw(8'd5, 32'h10, 8'd3, 2'b01);
    do_w(3, '0, 0);
    // second AW presented while the response is stalled; it must wait for the B handshake
    awid = 8'h22; awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    do_b(5);
    // the AW handshake happened on the final edge of do_b
    awvalid = 1'b0;
    set_model(8'h22, 32'h40, 8'd0, 2'b01);
    do_w(0, '0, 0);
    do_b(0);
    check_drained("stall");
  endtask

  task automatic test_wlast_err();
    do_aw(8'd9, 32'h20, 8'd3, 2'b01);
    do_w(1, '0, 0);
    do_b(1);
    check_drained("early_wlast");
    do_aw(8'd10, 32'h30, 8'd2, 2'b10);
    do_w(99, '0, 30);
    do_b(0);
    check_drained("missing_wlast");
  endtask

  task automatic test_fixed();
    do_aw(8'd3, 32'h8, 8'd2, 2'b00);
    do_w(2, 4'b0011, 0);
    do_b(0);
    check_drained("fixed");
  endtask

  task automatic test_window_edge();
    do_aw(8'd7, 32'h1000, 8'd0, 2'b01);
    do_w(0, '0, 0);
    do_b(0);
    check_drained("window");
    // INCR burst crossing the top of the byte address space
    do_aw(8'd8, 32'hFFFF_FFF8, 8'd3, 2'b01);
    do_w(3, '0, 0);
    do_b(0);
    check_drained("addr_wrap");
  endtask

  task automatic test_reset_mid_burst();
    do_aw(8'd4, 32'h100, 8'd7, 2'b01);
    drive_beat(0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, mem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset got aw=%b w=%b b=%b we=%b, required 0000",
               awready, wready, bvalid, mem_we);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({awready, bvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset got awready=%b bvalid=%b, required 1 0", awready, bvalid);
    end
    check_drained("reset_burst");
    @(posedge clk); #1;
    do_aw(8'd6, 32'h200, 8'd0, 2'b01);
    do_w(0, '0, 0);
    do_b(0);
    check_drained("after_reset");
  endtask

  task automatic test_long_burst();
    do_aw(8'hAB, 32'h0, 8'd255, 2'b01);
    do_w(255, '0, 0);
    do_b(0);
    check_drained("len255");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int la, mode;
      logic [7:0] len;
      mode = $urandom_range(0, 3);
      a = (mode == 0) ? $urandom :
          (mode == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) :
                        32'($urandom_range(0, 4095));
      len = 8'($urandom_range(0, 9));
      la = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
      do_aw(IW'($urandom), a, len, 2'($urandom_range(0, 2)));
      do_w(la, '0, 25);
      do_b($urandom_range(0, 3));
      check_drained("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bready_stall();
    test_wlast_err();
    test_fixed();
    test_window_edge();
    test_reset_mid_burst();
    test_long_burst();
    test_random();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
